// File: rtl/maple_rx.sv
// Maple bus frame receiver.
// Synchronises the pin1/pin5 lines returned from maple_ports. It detects the
// start pattern, decodes two-phase data bits into bytes (MSB first) and
// detects the end pattern. Frame boundaries and framing errors are reported
// as one-cycle strobes.
//
// Ports:
//   clk, rst      - system clock, synchronous active-high reset
//   in_p1, in_p5  - asynchronous SDCKA / SDCKB lines
//   enable        - 0 holds the receiver in idle and ignores the lines
//   data          - last received byte (held until the next byte)
//   data_valid    - strobe when data updates
//   frame_start   - strobe when a valid start pattern completes
//   frame_end     - strobe when a valid end pattern lands on a byte boundary
//   frame_error   - strobe on a framing error or timeout
//   busy          - high whenever the receiver is not idle
module maple_rx #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned TW             = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_p1,
  input  logic       in_p5,
  input  logic       enable,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_start,
  output logic       frame_end,
  output logic       frame_error,
  output logic       busy
);

  typedef enum logic [2:0] {
    StIdle, StStart, StDataA, StDataB, StEnd, StWaitIdle
  } state_e;

  logic [SYNC_STAGES-1:0] p1_sync_q, p5_sync_q;
  logic                   p1_dly_q, p5_dly_q;
  logic                   p1, p5;
  logic                   p1_fall, p1_rise, p5_fall, p5_rise, any_edge;

  state_e        state_q, state_d;
  logic [2:0]    pulse_cnt_q, pulse_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [6:0]    sr_q, sr_d;
  logic [7:0]    data_q, data_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          hi_seen_q, hi_seen_d;
  logic          valid_q, valid_d;
  logic          start_q, start_d;
  logic          end_q, end_d;
  logic          error_q, error_d;
  logic          shift_en, shift_bit, counting, timeout;

  // Synchronisers idle high, matching the quiescent bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_sync_q <= '1;
      p5_sync_q <= '1;
      p1_dly_q  <= 1'b1;
      p5_dly_q  <= 1'b1;
    end else begin
      p1_sync_q <= {p1_sync_q[SYNC_STAGES-2:0], in_p1};
      p5_sync_q <= {p5_sync_q[SYNC_STAGES-2:0], in_p5};
      p1_dly_q  <= p1_sync_q[SYNC_STAGES-1];
      p5_dly_q  <= p5_sync_q[SYNC_STAGES-1];
    end
  end

  assign p1       = p1_sync_q[SYNC_STAGES-1];
  assign p5       = p5_sync_q[SYNC_STAGES-1];
  assign p1_fall  = p1_dly_q & ~p1;
  assign p1_rise  = ~p1_dly_q & p1;
  assign p5_fall  = p5_dly_q & ~p5;
  assign p5_rise  = ~p5_dly_q & p5;
  assign any_edge = p1_fall | p1_rise | p5_fall | p5_rise;

  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    sr_d        = sr_q;
    data_d      = data_q;
    hi_seen_d   = 1'b0;
    valid_d     = 1'b0;
    start_d     = 1'b0;
    end_d       = 1'b0;
    error_d     = 1'b0;
    shift_en    = 1'b0;
    shift_bit   = 1'b0;

    counting = (state_q != StIdle) && (state_q != StWaitIdle);
    timer_d  = (counting && !any_edge) ? timer_q + 1'b1 : '0;
    // An edge in the same cycle always restarts the timer, so a timeout
    // never coincides with an edge-driven strobe.
    timeout  = counting && !any_edge && (timer_q == TW'(TIMEOUT_CYCLES - 1));

    if (!enable) begin
      state_d = StIdle;
    end else if (timeout) begin
      error_d = 1'b1;
      state_d = StWaitIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (p1_fall && p5) begin
            state_d     = StStart;
            pulse_cnt_d = 3'd0;
          end
        end
        StStart: begin
          if (p1_rise) begin
            if (pulse_cnt_q == 3'd4) begin
              start_d   = 1'b1;
              bit_cnt_d = 3'd0;
              state_d   = StDataA;
            end else begin
              error_d = 1'b1;
              state_d = StWaitIdle;
            end
          end else if (p5_fall && pulse_cnt_q != 3'd7) begin
            pulse_cnt_d = pulse_cnt_q + 3'd1;
          end
        end
        StDataA: begin
          if (p1_fall && p5_fall) begin
            error_d = 1'b1;
            state_d = StWaitIdle;
          end else if (p1_fall) begin
            shift_en  = 1'b1;
            shift_bit = p5;
            state_d   = StDataB;
          end
        end
        StDataB: begin
          if (p1_fall && p5_fall) begin
            error_d = 1'b1;
            state_d = StWaitIdle;
          end else if (p5_fall) begin
            shift_en  = 1'b1;
            shift_bit = p1;
            state_d   = StDataA;
          end else if (p1_fall && !p5) begin
            // Second pin1 pulse of the end pattern; the bit shifted in the
            // preceding DATA_A was the first pulse, hence bit_cnt == 1.
            if (bit_cnt_q == 3'd1) begin
              state_d = StEnd;
            end else begin
              error_d = 1'b1;
              state_d = StWaitIdle;
            end
          end
        end
        StEnd: begin
          if (p5_rise && p1) begin
            end_d   = 1'b1;
            state_d = StIdle;
          end
        end
        StWaitIdle: begin
          if (p1 && p5) begin
            if (hi_seen_q) state_d = StIdle;
            else           hi_seen_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (shift_en) begin
      sr_d      = {sr_q[5:0], shift_bit};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        data_d  = {sr_q, shift_bit};
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pulse_cnt_q <= '0;
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      data_q      <= '0;
      timer_q     <= '0;
      hi_seen_q   <= 1'b0;
      valid_q     <= 1'b0;
      start_q     <= 1'b0;
      end_q       <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pulse_cnt_q <= pulse_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      data_q      <= data_d;
      timer_q     <= timer_d;
      hi_seen_q   <= hi_seen_d;
      valid_q     <= valid_d;
      start_q     <= start_d;
      end_q       <= end_d;
      error_q     <= error_d;
    end
  end

  assign data        = data_q;
  assign data_valid  = valid_q;
  assign frame_start = start_q;
  assign frame_end   = end_q;
  assign frame_error = error_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_maple_rx.sv
// Testbench for maple_rx: random Maple frames are driven onto the pins, a
// frame-level model queues the expected strobes, and a separate monitor
// process compares every strobe the receiver produces against that queue.
module tb_maple_rx;

  localparam int S = 2;
  localparam int T = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_p1, in_p5, enable;
  logic [7:0] data;
  logic       data_valid, frame_start, frame_end, frame_error, busy;

  maple_rx #(
    .SYNC_STAGES(S),
    .TIMEOUT_CYCLES(T),
    .TW(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_p1(in_p1),
    .in_p5(in_p5),
    .enable(enable),
    .data(data),
    .data_valid(data_valid),
    .frame_start(frame_start),
    .frame_end(frame_end),
    .frame_error(frame_error),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EvStart = 0, EvByte = 1, EvEnd = 2, EvError = 3} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [7:0] data;
    int         at;  // expected cycle, -1 when only the order matters
  } ev_t;

  ev_t        exp_q[$];
  int         fbits[$];
  int         checks = 0;
  int         errors = 0;
  int         last_change = 0;
  logic [7:0] last_byte = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input ev_kind_e kind, input logic [7:0] d, input int at);
    ev_t e;
    e.kind = kind;
    e.data = d;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  // Reference model: one start, one byte per complete group of 8 bits
  // (MSB first), then an end only if the bit count is a whole number of bytes.
  task automatic model_frame(input bit with_end);
    int v;
    push(EvStart, 8'h00, -1);
    for (int i = 0; i < fbits.size() / 8; i++) begin
      v = 0;
      for (int k = 0; k < 8; k++) v = v * 2 + fbits[8 * i + k];
      push(EvByte, 8'(v), -1);
      last_byte = 8'(v);
    end
    if (with_end) push((fbits.size() % 8 == 0) ? EvEnd : EvError, 8'h00, -1);
  endtask

  task automatic gap();
    repeat ($urandom_range(6, 3)) @(posedge clk);
  endtask

  task automatic set_p1(input logic v);
    if (in_p1 !== v) begin
      @(posedge clk); #1;
      in_p1 = v;
      last_change = cyc;
      gap();
    end
  endtask

  task automatic set_p5(input logic v);
    if (in_p5 !== v) begin
      @(posedge clk); #1;
      in_p5 = v;
      last_change = cyc;
      gap();
    end
  endtask

  task automatic send_start(input int pulses);
    set_p1(1'b1);
    set_p5(1'b1);
    repeat (8) @(posedge clk);
    set_p1(1'b0);
    for (int i = 0; i < pulses; i++) begin
      set_p5(1'b0);
      set_p5(1'b1);
    end
    set_p1(1'b1);
  endtask

  // Even-indexed bits are clocked by a pin1 fall, odd ones by a pin5 fall.
  task automatic send_bits();
    for (int i = 0; i < fbits.size(); i++) begin
      if (i % 2 == 0) begin
        set_p1(1'b1);
        set_p5(fbits[i][0]);
        set_p1(1'b0);
      end else begin
        set_p5(1'b1);
        set_p1(fbits[i][0]);
        set_p5(1'b0);
      end
    end
  endtask

  task automatic send_end();
    set_p1(1'b1);
    set_p1(1'b0);
    set_p1(1'b1);
    set_p1(1'b0);
    set_p1(1'b1);
    set_p5(1'b1);
  endtask

  task automatic load_byte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) fbits.push_back(int'(b[k]));
  endtask

  task automatic load_random_bytes(input int n);
    fbits.delete();
    for (int i = 0; i < n; i++) load_byte(8'($urandom_range(255, 0)));
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (10) @(posedge clk);
    check(name, exp_q.size(), 0);
  endtask

  task automatic full_frame(input string name);
    model_frame(1'b1);
    send_start(4);
    send_bits();
    send_end();
    drain(name);
  endtask

  task automatic mon_one(input ev_kind_e kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d, expected none (cycle %0d)", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(kind), 32'(e.kind));
      if (kind == EvByte) check("byte_data", 32'(data), 32'(e.data));
      if (e.at >= 0) check("event_cycle", cyc, e.at);
      if (kind == EvEnd) check("busy_with_end", 32'(busy), 0);
    end
  endtask

  initial begin
    int n;
    rst    = 1'b1;
    enable = 1'b1;
    in_p1  = 1'b1;
    in_p5  = 1'b1;
    fork
      begin : monitor
        forever begin
          @(negedge clk);
          if (!rst) begin
            n = int'(frame_start) + int'(frame_end) + int'(frame_error) + int'(data_valid);
            if (n > 1) check("strobe_exclusive", n, 1);
            if (data_valid)  mon_one(EvByte);
            if (frame_start) mon_one(EvStart);
            if (frame_end)   mon_one(EvEnd);
            if (frame_error) mon_one(EvError);
          end
        end
      end
      begin : stimulus
        // Reset while the lines toggle.
        for (int i = 0; i < 20; i++) begin
          @(posedge clk); #1;
          in_p1 = 1'($urandom_range(1, 0));
          in_p5 = 1'($urandom_range(1, 0));
        end
        @(posedge clk); #1;
        in_p1 = 1'b1;
        in_p5 = 1'b1;
        rst   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("reset_data", 32'(data), 0);
        check("reset_valid", 32'(data_valid), 0);
        check("reset_start", 32'(frame_start), 0);
        check("reset_end", 32'(frame_end), 0);
        check("reset_error", 32'(frame_error), 0);
        check("reset_busy", 32'(busy), 0);

        // Directed frame 0xA5, 0x3C.
        fbits.delete();
        load_byte(8'hA5);
        load_byte(8'h3C);
        full_frame("frame_a5_3c");
        check("data_hold_3c", 32'(data), 32'h3C);

        // Start with only three pin5 pulses, then a good frame.
        push(EvError, 8'h00, -1);
        send_start(3);
        drain("short_start");
        load_random_bytes(2);
        full_frame("after_short_start");

        // End pattern after 12 bits.
        load_random_bytes(2);
        void'(fbits.pop_back());
        void'(fbits.pop_back());
        void'(fbits.pop_back());
        void'(fbits.pop_back());
        full_frame("end_after_12_bits");

        // Lines frozen mid-byte: error T cycles after the last edge's strobe slot.
        load_random_bytes(1);
        for (int i = 0; i < 5; i++) void'(fbits.pop_back());
        push(EvStart, 8'h00, -1);
        send_start(4);
        send_bits();
        push(EvError, 8'h00, last_change + S + 1 + T);
        drain("timeout");

        // enable dropped mid-byte.
        load_random_bytes(1);
        for (int i = 0; i < 3; i++) void'(fbits.pop_back());
        push(EvStart, 8'h00, -1);
        send_start(4);
        send_bits();
        drain("before_disable");
        @(posedge clk); #1;
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("busy_after_disable", 32'(busy), 0);
        check("data_held_disable", 32'(data), 32'(last_byte));
        set_p1(1'b1);
        set_p5(1'b1);
        @(posedge clk); #1;
        enable = 1'b1;
        load_random_bytes(1);
        full_frame("after_disable");

        // Random frames: good, misaligned end, or bad start pulse count.
        for (int f = 0; f < 8; f++) begin
          case ($urandom_range(2, 0))
            0: begin
              load_random_bytes(int'($urandom_range(3, 1)));
              full_frame("random_good");
            end
            1: begin
              load_random_bytes(3);
              n = 2 * int'($urandom_range(11, 1));
              if (n % 8 == 0) n = n + 2;
              while (fbits.size() > n) void'(fbits.pop_back());
              full_frame("random_misaligned");
            end
            default: begin
              n = int'($urandom_range(6, 1));
              if (n == 4) n = 5;
              push(EvError, 8'h00, -1);
              send_start(n);
              drain("random_bad_start");
            end
          endcase
        end
        drain("final_queue_empty");
      end
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
